// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master engines.
// Also holds the quarter-phase names used to place SCL edges and SDA activity.
package i2c_pkg;
    localparam int MAXB = 15;
    localparam int BCW  = $clog2(MAXB + 1);

    localparam logic [1:0] Q_LOW0  = 2'd0;
    localparam logic [1:0] Q_LOW1  = 2'd1;
    localparam logic [1:0] Q_HIGH0 = 2'd2;
    localparam logic [1:0] Q_HIGH1 = 2'd3;

    typedef enum logic [2:0] {IDLE, START, LOAD, BIT, ACK, STOP, DONE} i2c_tx_state_t;
endpackage

// File: rtl/i2c_transmit_if.sv
// Control-side handshake between the register file/control FSM and the write engine.
interface i2c_transmit_if;
    import i2c_pkg::*;

    logic           i2c_ready;
    logic [BCW-1:0] i2c_data_bytes;
    logic [7:0]     i2c_data;
    logic           i2c_data_req;
    logic           i2c_busy;
    logic           i2c_done;
    logic           i2c_ack_err;

    modport master (output i2c_ready, i2c_data_bytes, i2c_data,
                    input  i2c_data_req, i2c_busy, i2c_done, i2c_ack_err);
    modport slave  (input  i2c_ready, i2c_data_bytes, i2c_data,
                    output i2c_data_req, i2c_busy, i2c_done, i2c_ack_err);
endinterface

// File: rtl/i2c_qtick.sv
// Quarter-period timebase: tick marks the last clk of each DIV-long quarter, q counts quarters.
module i2c_qtick #(
    parameter int DIV = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    output logic       tick,
    output logic [1:0] q
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] phase_q, phase_d;
    logic [1:0]    q_q, q_d;

    assign tick = (phase_q == PW'(DIV - 1));
    assign q    = q_q;

    always_comb begin
        phase_d = phase_q + PW'(1);
        q_d     = q_q;
        if (clr) begin
            phase_d = '0;
            q_d     = '0;
        end else if (tick) begin
            phase_d = '0;
            q_d     = q_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            q_q     <= '0;
        end else begin
            phase_q <= phase_d;
            q_q     <= q_d;
        end
    end
endmodule

// File: rtl/i2c_transmit.sv
// I2C master write engine: START, N bytes MSB-first with ACK check, STOP.
// Bus outputs decode straight from state so a reset releases SCL/SDA in the same cycle.
module i2c_transmit
    import i2c_pkg::*;
#(
    parameter int DIV = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    i2c_transmit_if.slave ctl,
    output logic          i2c_scl,
    inout  wire           i2c_sda
);
    i2c_tx_state_t  state_q, state_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           ack_bit_q, ack_bit_d;
    logic           ack_err_q, ack_err_d;
    logic           tick, qclr, sda_oe, sda_in, req;
    logic [1:0]     q;

    // Timebase restarts so that START and every byte begin at quarter 0.
    assign qclr = (state_q == IDLE) || (state_q == LOAD) || (state_q == DONE);

    i2c_qtick #(.DIV(DIV)) u_qtick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (qclr),
        .tick  (tick),
        .q     (q)
    );

    assign i2c_sda = sda_oe ? 1'b0 : 1'bz;
    assign sda_in  = i2c_sda;

    assign ctl.i2c_data_req = req;
    assign ctl.i2c_busy     = (state_q == START) || (state_q == LOAD) || (state_q == BIT) ||
                              (state_q == ACK)   || (state_q == STOP);
    assign ctl.i2c_done     = (state_q == DONE);
    assign ctl.i2c_ack_err  = ack_err_q;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ack_bit_d  = ack_bit_q;
        ack_err_d  = ack_err_q;
        i2c_scl    = 1'b1;
        sda_oe     = 1'b0;
        req        = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctl.i2c_ready) begin
                    if (ctl.i2c_data_bytes != '0) begin
                        byte_cnt_d = ctl.i2c_data_bytes;
                        ack_err_d  = 1'b0;
                        state_d    = START;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            START: begin
                sda_oe = 1'b1;
                if (tick && q == Q_LOW1) state_d = LOAD;
            end
            LOAD: begin
                i2c_scl   = 1'b0;
                sda_oe    = 1'b1;
                req       = 1'b1;
                shift_d   = ctl.i2c_data;
                bit_cnt_d = 3'd7;
                state_d   = BIT;
            end
            BIT: begin
                i2c_scl = q[1];
                sda_oe  = ~shift_q[7];
                if (tick && q == Q_HIGH1) begin
                    if (bit_cnt_q == 3'd0) begin
                        state_d = ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        shift_d   = {shift_q[6:0], 1'b0};
                    end
                end
            end
            ACK: begin
                i2c_scl = q[1];
                if (tick && q == Q_HIGH0) ack_bit_d = sda_in;
                if (tick && q == Q_HIGH1) begin
                    if (ack_bit_q) begin
                        ack_err_d = 1'b1;
                        state_d   = STOP;
                    end else if (byte_cnt_q == BCW'(1)) begin
                        state_d = STOP;
                    end else begin
                        byte_cnt_d = byte_cnt_q - BCW'(1);
                        state_d    = LOAD;
                    end
                end
            end
            STOP: begin
                i2c_scl = (q != Q_LOW0);
                sda_oe  = (q == Q_LOW0) || (q == Q_LOW1);
                if (tick && q == Q_HIGH0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ack_bit_q  <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ack_bit_q  <= ack_bit_d;
            ack_err_q  <= ack_err_d;
        end
    end
endmodule
